video_timing_sink: RTL and testbench
====================================

VIDEO_TIMING_SINK -- requirements
Module: video_timing_sink

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800, meaning visible pixels per line.
REQ-002 SHALL have parameters H_FP 56, H_SYNC 120, H_BP 64, meaning horizontal front porch, sync and back porch, in pixels.
REQ-003 SHALL have parameters V_ACTIVE 600, V_FP 37, V_SYNC 6, V_BP 23, meaning vertical timing, in lines.
REQ-004 SHALL have parameter PIXEL_WIDTH, default 8, meaning pixel data width.
REQ-005 SHALL have port pixel_clk, input, 1 bit: sole clock, all logic rising-edge.
REQ-006 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port pixel_in_data, input, PIXEL_WIDTH bits: upstream pixel.
REQ-008 SHALL have port pixel_in_valid, input, 1 bit: pixel_in_data valid.
REQ-009 SHALL have port pixel_in_ready, output, 1 bit: request that upstream present a pixel next cycle.
REQ-010 SHALL have ports video_out_pixel (output, PIXEL_WIDTH), video_out_de, video_out_hsync, video_out_vsync (output, 1 bit each).
REQ-011 SHALL have port frame_start, output, 1 bit: one-cycle pulse at the first active pixel of a frame.
REQ-012 SHALL have port underflow, output, 1 bit: sticky missing-pixel flag.

Function
REQ-013 SHALL keep h_cnt in 0..H_TOTAL-1 and v_cnt in 0..V_TOTAL-1, where H_TOTAL = sum of horizontal parameters and V_TOTAL = sum of vertical parameters (defaults 1040 and 666).
REQ-014 SHALL increment h_cnt every cycle, wrap H_TOTAL-1 -> 0, and increment v_cnt on that wrap, with V_TOTAL-1 -> 0.
REQ-015 SHALL define active = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
REQ-016 SHALL assert pixel_in_ready combinationally iff the counter position of the next cycle is active and rst_n = 1, compensating the upstream one-cycle ROM read latency.
REQ-017 SHALL, in an active cycle, consume pixel_in_data when pixel_in_valid = 1; pixel_in_valid outside active cycles SHALL be ignored, with no data consumed.
REQ-018 SHALL, in an active cycle with pixel_in_valid = 0, substitute pixel value 0 and set underflow, which remains set until reset.
REQ-019 SHALL register all video outputs with latency 1: outputs in cycle t+1 reflect the counter position at cycle t.
REQ-020 SHALL drive video_out_de = active, and video_out_pixel = consumed or substituted pixel when active, else 0.
REQ-021 SHALL drive video_out_hsync = 1 for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), with positive polarity.
REQ-022 SHALL drive video_out_vsync = 1 for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), with positive polarity.
REQ-023 SHALL pulse frame_start for exactly one cycle, aligned with the video_out_de of pixel (0,0).
REQ-024 SHALL size counter widths with $clog2 of H_TOTAL and V_TOTAL; comparisons SHALL NOT truncate.

Reset
REQ-025 SHALL, while rst_n = 0, set h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1, and hold all outputs at 0, including pixel_in_ready and underflow.
REQ-026 SHALL, in the first cycle after reset release, assert pixel_in_ready because the next position is (0,0), so the first active pixel never underflows.
REQ-027 SHALL, on reset mid-frame, abandon the frame immediately; the next frame restarts from (0,0) per REQ-026.

Configuration
REQ-028 SHALL, with macro VIDEO_UNDERFLOW_COUNT_EN defined, add output underflow_count (16 bits), which counts underflow cycles, saturates at 0xFFFF, and is reset to 0.
REQ-029 SHALL, without VIDEO_UNDERFLOW_COUNT_EN, omit the port and counter; all other behaviour SHALL be identical.

Structure
REQ-030 SHALL place the default SVGA timing constants and H_TOTAL/V_TOTAL derivation in shared package video_timing_pkg.
REQ-031 SHALL implement h/v counting and sync/active decode in sub-module video_timing_counter, instanced once.

Verification
REQ-032 SHALL use small timing parameters (H 4/1/2/1, V 3/1/1/1) and always-valid upstream; each frame SHALL show 12 de cycles, hsync 2 cycles per 8-cycle line, vsync 8 cycles per 6-line frame, and underflow = 0.
REQ-033 SHALL release reset with an upstream 1-cycle ROM model holding pixel = index; the first video_out_pixel SHALL be 0, frame_start SHALL coincide with it, and pixels SHALL run 0..11 then wrap to 0.
REQ-034 SHALL drop pixel_in_valid for active pixel 5; video_out_pixel SHALL be 0 for that pixel, underflow SHALL become 1 and stay 1, and underflow_count SHALL be 1 when enabled.
REQ-035 SHALL assert pixel_in_valid during blanking; no data SHALL be consumed and video_out_pixel SHALL stay 0 with de = 0.
REQ-036 SHALL assert rst_n = 0 for 1 cycle at line 1, pixel 2; outputs SHALL be 0 in the next cycle, and a complete frame SHALL restart with frame_start after release.
REQ-037 SHALL force 70000 underflow cycles with VIDEO_UNDERFLOW_COUNT_EN; underflow_count SHALL saturate at 0xFFFF.

Source files
------------

// File: rtl/video_timing_pkg.sv
// video_timing_pkg: default SVGA timing constants and total/range helpers shared by the sink.
package video_timing_pkg;
  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP = 56;
  localparam int DEF_H_SYNC = 120;
  localparam int DEF_H_BP = 64;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP = 37;
  localparam int DEF_V_SYNC = 6;
  localparam int DEF_V_BP = 23;
  localparam int DEF_PIXEL_WIDTH = 8;
  function automatic int total(input int a, input int b, input int c, input int d);
    return a + b + c + d;
  endfunction
  function automatic logic in_range(input int x, input int lo, input int n);
    return x >= lo && x < lo + n;
  endfunction
endpackage

// File: rtl/video_timing_counter.sv
// video_timing_counter: h/v position counters with active/sync decode of the current and next position.
module video_timing_counter
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP
) (
  input  logic pixel_clk,
  input  logic rst_n,
  output logic active,
  output logic hsync,
  output logic vsync,
  output logic origin,
  output logic next_active
);
  localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW = H_TOTAL > 1 ? $clog2(H_TOTAL) : 1;
  localparam int VW = V_TOTAL > 1 ? $clog2(V_TOTAL) : 1;
  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic h_wrap;
  // comparisons are done on int-extended counters so nothing truncates
  always_comb begin
    h_wrap = int'(h_cnt) == H_TOTAL - 1;
    h_nxt = h_wrap ? '0 : h_cnt + 1'b1;
    v_nxt = h_wrap ? (int'(v_cnt) == V_TOTAL - 1 ? '0 : v_cnt + 1'b1) : v_cnt;
    active = int'(h_cnt) < H_ACTIVE && int'(v_cnt) < V_ACTIVE;
    next_active = int'(h_nxt) < H_ACTIVE && int'(v_nxt) < V_ACTIVE;
    hsync = in_range(int'(h_cnt), H_ACTIVE + H_FP, H_SYNC);
    vsync = in_range(int'(v_cnt), V_ACTIVE + V_FP, V_SYNC);
    origin = h_cnt == '0 && v_cnt == '0;
  end
  // reset parks on the last position so the first counted position is (0,0)
  always_ff @(posedge pixel_clk)
    if (!rst_n) begin
      h_cnt <= HW'(H_TOTAL - 1);
      v_cnt <= VW'(V_TOTAL - 1);
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
endmodule

// File: rtl/video_timing_sink.sv
// video_timing_sink: pulls pixels one cycle ahead from a ROM-latency upstream and emits registered video timing.
// Optional macro VIDEO_UNDERFLOW_COUNT_EN adds a saturating 16-bit underflow_count output.
module video_timing_sink
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH
) (
  input  logic                   pixel_clk,
  input  logic                   rst_n,
  input  logic [PIXEL_WIDTH-1:0] pixel_in_data,
  input  logic                   pixel_in_valid,
  output logic                   pixel_in_ready,
  output logic [PIXEL_WIDTH-1:0] video_out_pixel,
  output logic                   video_out_de,
  output logic                   video_out_hsync,
  output logic                   video_out_vsync,
  output logic                   frame_start,
  output logic                   underflow
`ifdef VIDEO_UNDERFLOW_COUNT_EN
  ,
  output logic [15:0]            underflow_count
`endif
);
  logic active, hsync, vsync, origin, next_active;
  video_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_counter (
    .pixel_clk(pixel_clk),
    .rst_n(rst_n),
    .active(active),
    .hsync(hsync),
    .vsync(vsync),
    .origin(origin),
    .next_active(next_active)
  );
  // request one cycle early to cover the upstream read latency
  assign pixel_in_ready = rst_n & next_active;
  always_ff @(posedge pixel_clk)
    if (!rst_n) begin
      video_out_pixel <= '0;
      video_out_de <= 1'b0;
      video_out_hsync <= 1'b0;
      video_out_vsync <= 1'b0;
      frame_start <= 1'b0;
      underflow <= 1'b0;
    end else begin
      video_out_pixel <= (active && pixel_in_valid) ? pixel_in_data : '0;
      video_out_de <= active;
      video_out_hsync <= hsync;
      video_out_vsync <= vsync;
      frame_start <= active && origin;
      underflow <= underflow | (active & ~pixel_in_valid);
    end
`ifdef VIDEO_UNDERFLOW_COUNT_EN
  always_ff @(posedge pixel_clk)
    if (!rst_n) underflow_count <= '0;
    else if (active && !pixel_in_valid && underflow_count != 16'hFFFF) underflow_count <= underflow_count + 16'd1;
`endif
endmodule

// File: tb/tb_video_timing_sink.sv
// tb_video_timing_sink: scoreboard bench for video_timing_sink on a tiny 8x6 timing with a 1-cycle ROM upstream.
module tb_video_timing_sink;
  typedef struct packed {
    logic de, hs, vs, fs, uf;
    logic [7:0] pix;
    logic [15:0] cnt;
  } exp_t;
  logic pixel_clk = 1'b0;
  logic rst_n = 1'b0;
  logic pixel_in_valid = 1'b1;
  logic junk_on = 1'b0;
  logic [7:0] rom_data = 8'd0;
  logic [7:0] rom_idx = 8'd0;
  logic [7:0] pixel_in_data;
  logic pixel_in_ready, video_out_de, video_out_hsync, video_out_vsync, frame_start, underflow;
  logic [7:0] video_out_pixel;
`ifdef VIDEO_UNDERFLOW_COUNT_EN
  logic [15:0] underflow_count;
`endif
  exp_t q[$];
  int k = 47;
  int checks = 0;
  int fails = 0;
  logic uf_m = 1'b0;
  logic [15:0] cnt_m = 16'd0;

  always #5 pixel_clk = ~pixel_clk;
  assign pixel_in_data = junk_on ? 8'hAA : rom_data;
  // upstream ROM: a request in one cycle yields pixel = index in the next
  always @(posedge pixel_clk)
    if (!rst_n) rom_idx <= 8'd0;
    else if (pixel_in_ready) begin
      rom_data <= rom_idx;
      rom_idx <= (rom_idx == 8'd11) ? 8'd0 : rom_idx + 8'd1;
    end

  video_timing_sink #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .PIXEL_WIDTH(8)
  ) dut (
    .pixel_clk(pixel_clk),
    .rst_n(rst_n),
    .pixel_in_data(pixel_in_data),
    .pixel_in_valid(pixel_in_valid),
    .pixel_in_ready(pixel_in_ready),
    .video_out_pixel(video_out_pixel),
    .video_out_de(video_out_de),
    .video_out_hsync(video_out_hsync),
    .video_out_vsync(video_out_vsync),
    .frame_start(frame_start),
    .underflow(underflow)
`ifdef VIDEO_UNDERFLOW_COUNT_EN
    ,
    .underflow_count(underflow_count)
`endif
  );

  function automatic logic de_at(input int p);
    return (p % 8) < 4 && (p / 8) < 3;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.de = video_out_de;
    o.hs = video_out_hsync;
    o.vs = video_out_vsync;
    o.fs = frame_start;
    o.uf = underflow;
    o.pix = video_out_pixel;
`ifdef VIDEO_UNDERFLOW_COUNT_EN
    o.cnt = underflow_count;
`else
    o.cnt = 16'd0;
`endif
    return o;
  endfunction

  function automatic string show(input exp_t e);
    return $sformatf("de=%b hs=%b vs=%b fs=%b uf=%b pix=%0d cnt=%0d", e.de, e.hs, e.vs, e.fs, e.uf, e.pix, e.cnt);
  endfunction

  // drives one cycle at frame position k and queues what the outputs must show one cycle later
  task automatic drive(input logic valid, input logic junk);
    exp_t e;
    int h, v;
    h = k % 8;
    v = k / 8;
    pixel_in_valid = valid;
    junk_on = junk && !de_at(k);
    if (de_at(k) && !valid) begin
      uf_m = 1'b1;
      if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
    end
    e.de = de_at(k);
    e.hs = h == 5 || h == 6;
    e.vs = v == 4;
    e.fs = k == 0;
    e.uf = uf_m;
    e.pix = (e.de && valid) ? 8'(v * 4 + h) : 8'd0;
`ifdef VIDEO_UNDERFLOW_COUNT_EN
    e.cnt = cnt_m;
`else
    e.cnt = 16'd0;
`endif
    q.push_back(e);
    @(negedge pixel_clk);
    k = (k + 1) % 48;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    pixel_in_valid = 1'b1;
    repeat (3) begin
      @(negedge pixel_clk);
      checks++;
      if ({observed(), pixel_in_ready} !== '0) begin
        fails++;
        $display("FAIL reset_hold got %s rdy=%b, want all 0", show(observed()), pixel_in_ready);
      end
    end
    rst_n = 1'b1;
    k = 47;
    #1;
    checks++;
    if (pixel_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready got %b want 1", pixel_in_ready);
    end
  endtask

  task automatic test_frames;
    exp_t e, got;
    int de_n, hs_n, vs_n, fs_n;
    de_n = 0; hs_n = 0; vs_n = 0; fs_n = 0;
    repeat (96) begin
      checks++;
      if (pixel_in_ready !== de_at((k + 1) % 48)) begin
        fails++;
        $display("FAIL ready pos=%0d got %b want %b", k, pixel_in_ready, de_at((k + 1) % 48));
      end
      drive(1'b1, 1'b0);
      e = q.pop_front();
      got = observed();
      checks++;
      if (got !== e) begin
        fails++;
        $display("FAIL frames got %s want %s", show(got), show(e));
      end
      de_n += int'(video_out_de);
      hs_n += int'(video_out_hsync);
      vs_n += int'(video_out_vsync);
      fs_n += int'(frame_start);
    end
    checks++;
    if ({de_n, hs_n, vs_n, fs_n} !== {32'd24, 32'd24, 32'd16, 32'd2}) begin
      fails++;
      $display("FAIL frame_counts got de=%0d hs=%0d vs=%0d fs=%0d want 24 24 16 2", de_n, hs_n, vs_n, fs_n);
    end
    checks++;
    if (underflow !== 1'b0) begin
      fails++;
      $display("FAIL no_underflow got %b want 0", underflow);
    end
  endtask

  task automatic test_blanking;
    exp_t e, got;
    repeat (48) begin
      drive(1'b1, 1'b1);
      e = q.pop_front();
      got = observed();
      checks++;
      if (got !== e) begin
        fails++;
        $display("FAIL blanking got %s want %s", show(got), show(e));
      end
    end
  endtask

  task automatic test_underflow;
    exp_t e, got;
    logic dropped;
    dropped = 1'b0;
    repeat (96) begin
      drive(!(k == 9 && !dropped), 1'b0);
      if (k == 10) dropped = 1'b1;
      e = q.pop_front();
      got = observed();
      checks++;
      if (got !== e) begin
        fails++;
        $display("FAIL underflow got %s want %s", show(got), show(e));
      end
    end
    checks++;
    if (underflow !== 1'b1) begin
      fails++;
      $display("FAIL underflow_sticky got %b want 1", underflow);
    end
`ifdef VIDEO_UNDERFLOW_COUNT_EN
    checks++;
    if (underflow_count !== 16'd1) begin
      fails++;
      $display("FAIL underflow_count got %0d want 1", underflow_count);
    end
`endif
  endtask

  task automatic test_reset_mid;
    exp_t e, got;
    int fs_n;
    fs_n = 0;
    while (k != 10) begin
      drive(1'b1, 1'b0);
      e = q.pop_front();
      got = observed();
      checks++;
      if (got !== e) begin
        fails++;
        $display("FAIL pre_reset got %s want %s", show(got), show(e));
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (pixel_in_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_ready got %b want 0", pixel_in_ready);
    end
    @(negedge pixel_clk);
    checks++;
    if (observed() !== '0) begin
      fails++;
      $display("FAIL mid_reset_outputs got %s want all 0", show(observed()));
    end
    q.delete();
    uf_m = 1'b0;
    cnt_m = 16'd0;
    rst_n = 1'b1;
    k = 47;
    repeat (49) begin
      drive(1'b1, 1'b0);
      e = q.pop_front();
      got = observed();
      checks++;
      if (got !== e) begin
        fails++;
        $display("FAIL restart got %s want %s", show(got), show(e));
      end
      fs_n += int'(frame_start);
    end
    checks++;
    if (fs_n !== 1) begin
      fails++;
      $display("FAIL restart_frame_start got %0d pulses want 1", fs_n);
    end
  endtask

`ifdef VIDEO_UNDERFLOW_COUNT_EN
  task automatic test_saturate;
    exp_t e, got;
    int n;
    n = 0;
    while (n < 70000) begin
      if (de_at(k)) n++;
      drive(1'b0, 1'b0);
      e = q.pop_front();
      got = observed();
      checks++;
      if (got !== e) begin
        fails++;
        $display("FAIL saturate got %s want %s", show(got), show(e));
      end
    end
    checks++;
    if (underflow_count !== 16'hFFFF) begin
      fails++;
      $display("FAIL saturate_final got %h want ffff", underflow_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frames();
    test_blanking();
    test_underflow();
    test_reset_mid();
`ifdef VIDEO_UNDERFLOW_COUNT_EN
    test_saturate();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
